tdm_demux_4ch: RTL and testbench
================================

// Module: tdm_demux_4ch
// PURPOSE
//  Time-division demultiplexer: receiving end of the round-robin sample stream built by the mux_4x1 stage.
//  Accepts one DATA_W sample per valid cycle and steers it, in channel order 0..NUM_CH-1, to a per-channel
//  output register. Channel 0 of each frame is marked by in_sync.
//  A HUNT/LOCKED FSM aligns to frames and flags sync errors. Sits between the serial link and per-channel consumers.
// PARAMETERS
//  DATA_W   8   sample width in bits (1..32)
//  NUM_CH   4   channels per frame; power of 2, 2..16; CH_W = $clog2(NUM_CH) derived internally
// PORTS
//  clk        in   1              single clock, all logic on rising edge
//  rst_n      in   1              asynchronous, active-low reset
//  in_valid   in   1              in_data/in_sync qualify this cycle
//  in_data    in   DATA_W         sample
//  in_sync    in   1              high with the channel-0 sample of every frame; ignored when in_valid=0
//  out_data   out  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W]; holds last written sample
//  out_valid  out  NUM_CH         one-cycle pulse, bit k = channel k register updated this cycle
//  frame_done out  1              one-cycle pulse when channel NUM_CH-1 written
//  locked     out  1              FSM in LOCKED
//  sync_err   out  1              one-cycle pulse on a sync violation
// BEHAVIOUR
//  Reset (async assert, sync release): out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0,
//   state=HUNT, ch_cnt=0. Reset mid-frame discards the partial frame; no pulses emitted for it.
//  All outputs registered. Latency: accepted sample at edge N appears on out_data/out_valid after edge N
//   (same edge that samples it), i.e. visible in cycle N+1.
//  in_valid=0: no state change, ch_cnt holds, all pulses 0.
//  HUNT:
//   - in_valid & !in_sync: sample dropped, no pulse, stay HUNT.
//   - in_valid & in_sync: write ch0, out_valid[0]=1, ch_cnt=1, -> LOCKED. No sync_err.
//  LOCKED, in_valid=1:
//   - ch_cnt!=0 & !in_sync: write ch ch_cnt, ch_cnt+=1 mod NUM_CH; frame_done=1 if ch_cnt==NUM_CH-1.
//   - ch_cnt==0 & in_sync: write ch0, ch_cnt=1 (normal frame start).
//   - ch_cnt!=0 & in_sync (early sync): sync_err=1; re-align: write ch0, ch_cnt=1, stay LOCKED;
//     partial frame abandoned, no frame_done.
//   - ch_cnt==0 & !in_sync (missing sync): sync_err=1; sample dropped; ch_cnt=0; -> HUNT.
//  ch_cnt wraps NUM_CH-1 -> 0 only via a normal write; never exceeds NUM_CH-1.
//  At most one out_valid bit set per cycle; frame_done coincides with out_valid[NUM_CH-1].
//  sync_err and frame_done never both 1 in one cycle.
//  Unwritten channels keep their previous value; no clearing on frame boundaries or errors.
//  locked = (state==LOCKED), registered.
// TESTING (DATA_W=8, NUM_CH=4)
//  1 Reset: rst_n=0 asynchronously mid-clock -> all outputs 0 immediately, locked=0.
//  2 Clean frame: valid each cycle 0xA0(sync),0xA1,0xA2,0xA3 -> out_valid 0001,0010,0100,1000;
//    out_data=0xA3A2A1A0; frame_done high with 1000; locked=1 after first sample.
//  3 HUNT drop: 0x11,0x22 without sync, then 0x33(sync) -> first two ignored; ch0=0x33, locked=1.
//  4 Early sync: after 0xA0(sync),0xA1, send 0xB0(sync) -> sync_err pulse; ch0=0xB0; next 0xB1 -> ch1.
//  5 Missing sync: full frame then 0xC0 without sync -> sync_err pulse, no out_valid, locked=0.
//  6 Gaps: in_valid toggled 1,0,0,1 over a frame -> ch_cnt holds during gaps; frame order intact.

Source files
------------

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receiving end of a round-robin TDM sample stream.
// Samples arrive one per valid cycle in channel order 0..NUM_CH-1, with
// in_sync marking channel 0. A HUNT/LOCKED FSM aligns to frame starts,
// steers each accepted sample into its channel register and flags sync errors.
//
// Handshake: in_valid qualifies in_data/in_sync for the current cycle. There is
// no backpressure (no ready); every valid cycle is consumed on that edge.
// When in_valid=0 nothing changes and all pulse outputs are 0 next cycle.
// All outputs are registered; a sample accepted at edge N is visible in cycle N+1.
module tdm_demux_4ch #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sync,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic                     frame_done,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic                frame_done_q, frame_done_d;
    logic                sync_err_q, sync_err_d;
    logic [NUM_CH-1:0]   out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   data_q [NUM_CH];

    // State register and per-cycle pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            ch_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            out_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            ch_cnt_q     <= ch_cnt_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Next-state logic: frame alignment, channel steering and error detection
    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        wr_en        = 1'b0;
        wr_ch        = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // Drop everything until a frame start is seen
                    if (in_sync) begin
                        wr_en    = 1'b1;
                        wr_ch    = '0;
                        ch_cnt_d = CH_W'(1);
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync) begin
                        // Normal frame start, or early sync that re-aligns to ch0
                        wr_en      = 1'b1;
                        wr_ch      = '0;
                        ch_cnt_d   = CH_W'(1);
                        sync_err_d = (ch_cnt_q != '0);
                    end else if (ch_cnt_q == '0) begin
                        // Expected a frame start but none came: lose lock
                        sync_err_d = 1'b1;
                        ch_cnt_d   = '0;
                        state_d    = HUNT;
                    end else begin
                        wr_en        = 1'b1;
                        wr_ch        = ch_cnt_q;
                        ch_cnt_d     = ch_cnt_q + CH_W'(1);
                        frame_done_d = (ch_cnt_q == LAST_CH);
                    end
                end
                default: begin
                    state_d  = HUNT;
                    ch_cnt_d = '0;
                end
            endcase
        end
    end

    // One-hot write strobe for the channel being updated this cycle
    always_comb begin
        out_valid_d = '0;
        if (wr_en) begin
            out_valid_d[wr_ch] = 1'b1;
        end
    end

    // Per-channel sample registers; unwritten channels hold their value
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q[k] <= '0;
            end else if (out_valid_d[k]) begin
                data_q[k] <= in_data;
            end
        end
        assign out_data[k*DATA_W +: DATA_W] = data_q[k];
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Testbench for tdm_demux_4ch (DATA_W=8, NUM_CH=4): directed scenarios
// followed by randomized traffic checked against a frame-level reference model.
module tb_tdm_demux_4ch;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int W      = NUM_CH * DATA_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sync;
  logic [W-1:0]      out_data;
  logic [NUM_CH-1:0] out_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position expected next, lock flag, channel contents
  bit                m_locked;
  int                m_pos;
  logic [DATA_W-1:0] m_ch [NUM_CH];
  logic [W-1:0]      exp_q [$];

  tdm_demux_4ch #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sync    (in_sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    for (int k = 0; k < NUM_CH; k++) w[k*DATA_W +: DATA_W] = m_ch[k];
    return w;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    for (int k = 0; k < NUM_CH; k++) m_ch[k] = '0;
    exp_q.delete();
  endtask

  // Drive one cycle, let the edge take it, then compare against the model
  task automatic step(input bit v, input bit s, input logic [DATA_W-1:0] d);
    int exp_vld;
    bit exp_fd;
    bit exp_err;
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    exp_vld = 0;
    exp_fd  = 0;
    exp_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_ch[0] = d; exp_vld = 1; m_pos = 1; m_locked = 1;
        end
      end else if (s) begin
        exp_err = (m_pos != 0);
        m_ch[0] = d; exp_vld = 1; m_pos = 1;
      end else if (m_pos == 0) begin
        exp_err = 1; m_locked = 0;
      end else begin
        m_ch[m_pos] = d;
        exp_vld = 1 << m_pos;
        exp_fd  = (m_pos == NUM_CH - 1);
        m_pos   = (m_pos + 1) % NUM_CH;
      end
    end
    if (exp_fd) exp_q.push_back(model_word());
    check("out_valid",  32'(out_valid),  32'(exp_vld));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("sync_err",   32'(sync_err),   32'(exp_err));
    check("locked",     32'(locked),     32'(m_locked));
    check("out_data",   32'(out_data),   32'(model_word()));
    if (frame_done) begin
      if (exp_q.size() == 0) check("frame_spurious", 32'(frame_done), 32'd0);
      else check("frame_word", 32'(out_data), 32'(exp_q.pop_front()));
    end
  endtask

  // Assert reset mid-clock, confirm outputs clear immediately, release off-edge
  task automatic mid_reset();
    in_valid = 0;
    in_sync  = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sync_err",   32'(sync_err),   32'd0);
    check("rst_locked",     32'(locked),     32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 0;
    in_sync  = 0;
    in_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("init_out_data", 32'(out_data), 32'd0);
    check("init_locked",   32'(locked),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // HUNT drop: no sync -> ignored, then sync locks
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    check("hunt_locked_before", 32'(locked), 32'd0);
    step(1, 1, 8'h33);
    check("hunt_ch0",    32'(out_data[7:0]), 32'h33);
    check("hunt_locked", 32'(locked),        32'd1);
    step(1, 0, 8'h34);
    step(1, 0, 8'h35);
    step(1, 0, 8'h36);

    // Clean frame
    step(1, 1, 8'hA0); check("clean_v0", 32'(out_valid), 32'b0001);
    step(1, 0, 8'hA1); check("clean_v1", 32'(out_valid), 32'b0010);
    step(1, 0, 8'hA2); check("clean_v2", 32'(out_valid), 32'b0100);
    step(1, 0, 8'hA3); check("clean_v3", 32'(out_valid), 32'b1000);
    check("clean_fd",   32'(frame_done), 32'd1);
    check("clean_word", 32'(out_data),   32'hA3A2A1A0);

    // Early sync re-aligns to ch0
    step(1, 1, 8'hA0);
    step(1, 0, 8'hA1);
    step(1, 1, 8'hB0);
    check("early_err", 32'(sync_err),      32'd1);
    check("early_ch0", 32'(out_data[7:0]), 32'hB0);
    step(1, 0, 8'hB1);
    check("early_ch1", 32'(out_valid), 32'b0010);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hB3);

    // Missing sync after a full frame
    step(1, 0, 8'hC0);
    check("miss_err",    32'(sync_err),  32'd1);
    check("miss_vld",    32'(out_valid), 32'd0);
    check("miss_locked", 32'(locked),    32'd0);

    // Gaps inside a frame
    step(1, 1, 8'hD0);
    step(0, 0, 8'hEE);
    step(0, 1, 8'hEF);
    step(1, 0, 8'hD1);
    check("gap_ch1", 32'(out_valid), 32'b0010);
    step(0, 0, 8'h00);
    step(1, 0, 8'hD2);
    step(1, 0, 8'hD3);
    check("gap_word", 32'(out_data), 32'hD3D2D1D0);

    // Reset mid-frame drops the partial frame
    step(1, 1, 8'hE0);
    step(1, 0, 8'hE1);
    mid_reset();
    step(1, 0, 8'h55);
    check("post_rst_locked", 32'(locked), 32'd0);

    // Randomized traffic: mostly well-formed frames with occasional sync faults
    for (int i = 0; i < 800; i++) begin
      bit v;
      bit s;
      v = ($urandom_range(0, 3) != 0);
      s = (m_locked ? (m_pos == 0) : ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 11) == 0) s = ~s;
      step(v, s, 8'($urandom));
      if (i == 400) mid_reset();
    end

    check("frames_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
